// File: rtl/multicycle_ctrl_fsm.sv
// Main decoder for the multicycle ARM core: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects plus raw (not condition-gated) write enables.
module multicycle_ctrl_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               MemReady,
  output logic               IRWrite,
  output logic               NextPC,
  output logic               AdrSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               ALUOp,
  output logic               RegW,
  output logic               MemW,
  output logic               Branch,
  output logic               Illegal,
  output logic [STATE_W-1:0] StateOut
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = STATE_W'(0),
    S_DECODE  = STATE_W'(1),
    S_MEMADR  = STATE_W'(2),
    S_MEMRD   = STATE_W'(3),
    S_MEMWB   = STATE_W'(4),
    S_MEMWR   = STATE_W'(5),
    S_EXECR   = STATE_W'(6),
    S_EXECI   = STATE_W'(7),
    S_ALUWB   = STATE_W'(8),
    S_BRANCH  = STATE_W'(9),
    S_UNKNOWN = STATE_W'(10)
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_irwrite;
  logic w_nextpc;
  logic w_regw;
  logic w_memw;
  logic w_branch;
  logic w_illegal;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = S_FETCH;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 1'b0;
    w_irwrite = 1'b0;
    w_nextpc  = 1'b0;
    w_regw    = 1'b0;
    w_memw    = 1'b0;
    w_branch  = 1'b0;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_irwrite = MemReady;
        w_nextpc  = MemReady;
        w_next    = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_UNKNOWN;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        w_next  = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        w_next = MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_regw    = 1'b1;
      end
      // Write enable stays high for the whole wait so the memory sees a stable request.
      S_MEMWR: begin
        AdrSrc = 1'b1;
        w_memw = 1'b1;
        w_next = MemReady ? S_FETCH : S_MEMWR;
      end
      S_EXECR: begin
        ALUOp  = 1'b1;
        w_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        w_regw = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_branch  = 1'b1;
      end
      S_UNKNOWN: begin
        w_illegal = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Enables are masked while reset is low so an abandoned instruction cannot write.
  assign IRWrite  = w_irwrite & reset;
  assign NextPC   = w_nextpc  & reset;
  assign RegW     = w_regw    & reset;
  assign MemW     = w_memw    & reset;
  assign Branch   = w_branch  & reset;
  assign Illegal  = w_illegal & reset;
  assign StateOut = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm: each instruction is expanded into its
// list of phases, wait phases are stretched by MemReady, and every cycle is compared.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b0;
  logic       MemReady = 1'b0;
  logic       IRWrite, NextPC, AdrSrc, ALUSrcA, ALUOp, RegW, MemW, Branch, Illegal;
  logic [1:0] ALUSrcB, ResultSrc;
  logic [3:0] StateOut;

  int n_pass = 0;
  int n_total = 0;

  multicycle_ctrl_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .Illegal(Illegal), .StateOut(StateOut)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [12:0] outs();
    return {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RegW, MemW, Branch, Illegal};
  endfunction

  // Expected outputs per phase: {IRW,NPC,AdrSrc,SrcA,SrcB,ResSrc,ALUOp,RegW,MemW,Branch,Illegal}
  function automatic logic [12:0] exp_out(input int ph, input logic mr);
    case (ph)
      0:  return {mr, mr, 11'b0_1_10_10_0_0000};
      1:  return 13'b0_0_0_1_10_10_0_0000;
      2:  return 13'b0_0_0_0_01_00_0_0000;
      3:  return 13'b0_0_1_0_00_00_0_0000;
      4:  return 13'b0_0_0_0_00_01_0_1000;
      5:  return 13'b0_0_1_0_00_00_0_0100;
      6:  return 13'b0_0_0_0_00_00_1_0000;
      7:  return 13'b0_0_0_0_01_00_1_0000;
      8:  return 13'b0_0_0_0_00_00_0_1000;
      9:  return 13'b0_0_0_0_01_10_0_0010;
      default: return 13'b0_0_0_0_00_00_0_0001;
    endcase
  endfunction

  function automatic bit is_wait(input int ph);
    return (ph == 0) || (ph == 3) || (ph == 5);
  endfunction

  function automatic int base_latency(input logic [1:0] op, input logic [5:0] fn);
    case (op)
      2'b00:   return 4;
      2'b01:   return fn[0] ? 5 : 4;
      default: return 3;
    endcase
  endfunction

  task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input int fetch_waits,
                           input int mem_waits, input bit rnd, input bit abort);
    int   ph[$];
    int   idx = 0;
    int   cyc = 0;
    int   waits = 0;
    int   phase_waits = 0;
    int   cur;
    logic mr;
    ph.push_back(0);
    ph.push_back(1);
    case (op)
      2'b00: begin ph.push_back(fn[5] ? 7 : 6); ph.push_back(8); end
      2'b01: begin
        ph.push_back(2);
        if (fn[0]) begin ph.push_back(3); ph.push_back(4); end
        else ph.push_back(5);
      end
      2'b10:   ph.push_back(9);
      default: ph.push_back(10);
    endcase
    while (idx < ph.size()) begin
      @(negedge clk);
      cur = ph[idx];
      if (is_wait(cur)) begin
        if (rnd) mr = (phase_waits < 6) ? ($urandom_range(0, 3) != 0) : 1'b1;
        else     mr = (phase_waits < ((cur == 0) ? fetch_waits : mem_waits)) ? 1'b0 : 1'b1;
      end else begin
        mr = 1'($urandom_range(0, 1));
      end
      MemReady = mr;
      if (cur == 0) begin
        Op    = 2'($urandom_range(0, 3));
        Funct = 6'($urandom_range(0, 63));
      end else begin
        Op    = op;
        Funct = fn;
      end
      #1;
      cyc++;
      chk("state", int'(StateOut), cur);
      chk("outputs", int'(outs()), int'(exp_out(cur, mr)));
      if (abort && cur == 5) begin
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_state", int'(StateOut), 0);
        chk("abort_memw", int'(MemW), 0);
        chk("abort_enables", int'({IRWrite, NextPC, RegW, Branch, Illegal}), 0);
        MemReady = 1'b0;
        reset = 1'b1;
        return;
      end
      if (is_wait(cur) && !mr) begin
        waits++;
        phase_waits++;
      end else begin
        idx++;
        phase_waits = 0;
      end
      if (cyc > 200) begin
        chk("instr_timeout", cyc, 0);
        return;
      end
    end
    chk("latency", cyc, base_latency(op, fn) + waits);
  endtask

  initial begin
    reset = 1'b0;
    MemReady = 1'b1;
    Op = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_state", int'(StateOut), 0);
    chk("reset_enables", int'({IRWrite, NextPC, RegW, MemW, Branch, Illegal}), 0);
    reset = 1'b1;
    #1;
    chk("release_irwrite", int'(IRWrite), 1);
    chk("release_nextpc", int'(NextPC), 1);
    MemReady = 1'b0;

    run_instr(2'b00, 6'b001000, 0, 0, 1'b0, 1'b0);
    run_instr(2'b00, 6'b101001, 0, 0, 1'b0, 1'b0);
    run_instr(2'b01, 6'b011001, 0, 3, 1'b0, 1'b0);
    run_instr(2'b01, 6'b011000, 2, 1, 1'b0, 1'b0);
    run_instr(2'b10, 6'b000000, 0, 0, 1'b0, 1'b0);
    run_instr(2'b11, 6'b000000, 1, 0, 1'b0, 1'b0);
    run_instr(2'b01, 6'b011000, 0, 3, 1'b0, 1'b1);
    run_instr(2'b00, 6'b000100, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      run_instr(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 0, 0, 1'b1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
